spi_bus_arbiter: RTL
====================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one SPI master bus (SCLK/MOSI/MISO) between N SPI requester cores (ALS, ACL2, ...).
//  Each requester holds req while it owns the bus; the arbiter grants round-robin.
//  It registers the granted requester's SCLK/MOSI/CS onto the pads and forces all other CS lines high.
//  An enforced idle gap follows every release. Sits in the top level between sensor cores and Pmod pins.
// PARAMETERS
//  N        2        number of requesters (2..8)
//  CS_GAP   4        Clock cycles all CS held high between grants (>=1)
//  CPOL     0        idle level of SCLK pad when no grant
//  TIMEOUT  1000000  max Clock cycles one grant may last (used only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  Clock         in   1  system clock
//  Reset         in   1  asynchronous, active-low reset
//  req           in   N  bus request per requester; held high for whole transaction
//  gnt           out  N  one-hot grant, registered
//  sclk_in       in   N  per-requester SCLK
//  mosi_in       in   N  per-requester MOSI
//  cs_in         in   N  per-requester CS, active low
//  SCLK          out  1  pad SCLK, registered
//  MOSI          out  1  pad MOSI, registered
//  CS            out  N  pad chip selects, active low, registered
//  busy          out  1  high in GRANT or GAP
//  timeout_flag  out  1  one-cycle pulse on forced revoke
// BEHAVIOUR
//  Reset values: gnt=0, SCLK=CPOL, MOSI=0, CS=all 1, busy=0, timeout_flag=0, rr pointer=0, state IDLE.
//  Reset is asynchronous; asserting it mid-transfer drops grant and CS immediately.
//  FSM:
//   IDLE: if any req is high, pick the first requester at or after the rr pointer (wrapping mod N).
//         Set gnt[k] on the next edge, go to GRANT, and set rr = (k+1) mod N.
//   GRANT: each cycle SCLK<=sclk_in[k], MOSI<=mosi_in[k], CS[k]<=cs_in[k]; other CS=1.
//          Pad path has 1 cycle latency, equal on all three signals.
//          When req[k] is low: gnt<=0, CS<=all 1, SCLK<=CPOL, MOSI<=0, go to GAP with the counter loaded with CS_GAP-1.
//   GAP: pads idle; count down; at 0 go to IDLE. Arbitration resumes in IDLE the next cycle.
//  Requests arriving during GRANT/GAP wait; no preemption.
//  Simultaneous requests resolve by the rr pointer. After ALS is granted, ACL2 wins the next tie.
//  A req dropping and another rising in the same cycle: the gap is still enforced.
//  A requester may only drive its bus after seeing gnt; gnt never changes while its req is high (except timeout).
//  MISO is not muxed: the pad fans out to all requesters; only the granted device has CS low.
//  Out-of-range index never granted; N=1 degenerates to pass-through with gap.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - A grant counter clears on entering GRANT.
//   - At TIMEOUT cycles the grant is revoked (same path as release), timeout_flag pulses 1 cycle, and the requester is masked.
//   - The masked requester cannot be regranted until its req has been seen low for 1 cycle.
//  SPI_ARB_TIMEOUT_EN not defined: no counter or mask; timeout_flag tied 0; a grant lasts until req drops.
// TESTING
//  1 Reset low, random inputs -> CS=2'b11, gnt=0, SCLK=CPOL, busy=0; hold through Reset release.
//  2 req=2'b01, toggle sclk_in[0] -> gnt=01 one cycle later; SCLK tracks sclk_in[0] delayed 1 cycle.
//    CS[1] stays 1; drop req -> CS=11 for exactly CS_GAP=4 cycles, busy=1.
//  3 req=2'b11 from IDLE after reset -> gnt=01; release -> after gap gnt=10; release, then req=11 -> gnt=01 (round-robin).
//  4 Granted 0, req[1] rises mid-transfer -> gnt stays 01, no glitch on CS[1].
//    Grant to 1 arrives CS_GAP+1 cycles after req[0] drops.
//  5 Reset asserted mid-GRANT -> CS=11, gnt=0 same cycle (async); after release IDLE, rr=0.
//  6 (SPI_ARB_TIMEOUT_EN, TIMEOUT=16) hold req[0] 40 cycles -> revoke at cycle 16, timeout_flag one pulse.
//    With req[1] high, 1 is granted after the gap; 0 is not regranted until req[0] toggles low.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one SPI master bus (SCLK/MOSI/CS pads) between N requester cores.
//   Round-robin grant, registered pad mux, enforced all-CS-high gap after
//   every release. MISO is not muxed: the pad fans out to every requester.
//   Optional grant watchdog: define SPI_ARB_TIMEOUT_EN to revoke grants that
//   last TIMEOUT cycles and mask the offender until it drops req.
//
// Handshake (req/gnt): a requester raises req and holds it for the whole
//   transaction. It may only drive its sclk/mosi/cs after it sees its gnt
//   bit high. gnt never changes while the owner's req is high (except on a
//   watchdog revoke). Dropping req ends the transaction; the pads go idle on
//   the same edge gnt falls.
module spi_bus_arbiter #(
    parameter int   N       = 2,
    parameter int   CS_GAP  = 4,
    parameter logic CPOL    = 1'b0,
    parameter int   TIMEOUT = 1000000
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    input  logic [N-1:0] sclk_in,
    input  logic [N-1:0] mosi_in,
    input  logic [N-1:0] cs_in,
    output logic         SCLK,
    output logic         MOSI,
    output logic [N-1:0] CS,
    output logic         busy,
    output logic         timeout_flag,
    output logic [1:0]   state_dbg
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr;
    logic [GW-1:0]   gap_cnt;
    logic [N-1:0]    eligible;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            tmo_hit;
    logic            end_grant;

    assign state_dbg = state;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] grant_cnt;
    logic [N-1:0]  mask;

    // A masked requester stays out of arbitration until its req is seen low.
    assign eligible = req & ~mask;
    assign tmo_hit  = (state == S_GRANT) && (grant_cnt == TW'(TIMEOUT - 1));

    // Watchdog: count grant cycles, revoke and mask the owner at TIMEOUT.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            grant_cnt    <= '0;
            mask         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= 1'b0;
            mask         <= mask & req;
            if (state == S_IDLE) begin
                grant_cnt <= '0;
            end else if (state == S_GRANT) begin
                // A voluntary release on the same edge wins over the revoke.
                if (req[owner] && tmo_hit) begin
                    timeout_flag <= 1'b1;
                    mask[owner]  <= 1'b1;
                end else begin
                    grant_cnt <= grant_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign eligible     = req;
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign end_grant = !req[owner] || tmo_hit;

    // Round-robin pick: first eligible requester at or after rr, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((int'(rr) + i) % N);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Arbiter FSM with registered grant, pad mux and busy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            gnt     <= '0;
            owner   <= '0;
            rr      <= '0;
            gap_cnt <= '0;
            SCLK    <= CPOL;
            MOSI    <= 1'b0;
            CS      <= '1;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    SCLK <= CPOL;
                    MOSI <= 1'b0;
                    CS   <= '1;
                    if (pick_valid) begin
                        gnt           <= '0;
                        gnt[pick_idx] <= 1'b1;
                        owner         <= pick_idx;
                        rr            <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                        busy          <= 1'b1;
                        state         <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (end_grant) begin
                        gnt     <= '0;
                        CS      <= '1;
                        SCLK    <= CPOL;
                        MOSI    <= 1'b0;
                        gap_cnt <= GW'(CS_GAP - 1);
                        state   <= S_GAP;
                    end else begin
                        // Same one-cycle latency on all three pad signals.
                        SCLK      <= sclk_in[owner];
                        MOSI      <= mosi_in[owner];
                        CS        <= '1;
                        CS[owner] <= cs_in[owner];
                    end
                end
                S_GAP: begin
                    SCLK <= CPOL;
                    MOSI <= 1'b0;
                    CS   <= '1;
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    SCLK  <= CPOL;
                    MOSI  <= 1'b0;
                    CS    <= '1;
                end
            endcase
        end
    end

endmodule
